// File: rtl/me_pkg.sv
// Purpose: shared sizes, FSM states and candidate payload for the motion-estimator control.
//   BLK   : block edge = PE count = offsets per axis
//   LAST  : final counter value of a search
//   cand_t: candidate {k, v} handed to the min-tracker
package me_pkg;

  localparam int unsigned BLK  = 16;
  localparam int unsigned BSQ  = BLK * BLK;
  localparam int unsigned LAST = BLK * BSQ + BLK - 1;

  localparam int unsigned DW = 8;                  // distortion width
  localparam int unsigned KW = $clog2(BLK);        // offset / column-in-block width
  localparam int unsigned RW = $clog2(BSQ);        // reference address width
  localparam int unsigned TW = $clog2(LAST + 1);   // sequencer counter width
  localparam int unsigned FW = KW + 1;             // search row/col field width
  localparam int unsigned SW = 2 * FW;             // search address width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [KW-1:0] v;
  } cand_t;

  // Search row for counter row n: n/BLK + n mod BLK.
  function automatic logic [FW-1:0] diag_row(input logic [TW-KW-1:0] n);
    return FW'(n[TW-KW-1:KW]) + FW'(n[KW-1:0]);
  endfunction

endpackage

// File: rtl/me_compare.sv
// Purpose: selects the capturing PE's distortion and tracks the running minimum.
//   i_cap_valid : a PE has a finished SAD this cycle
//   i_first     : first capture of the search, load unconditionally
//   i_cand      : candidate offsets {k, v}
//   i_acc       : all PE accumulators, PE k on [DW*k +: DW]
//   o_best_dist / o_motion_x / o_motion_y : registered best match
module me_compare
  import me_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cap_valid,
  input  logic              i_first,
  input  cand_t             i_cand,
  input  logic [DW*BLK-1:0] i_acc,
  output logic [DW-1:0]     o_best_dist,
  output logic [KW-1:0]     o_motion_x,
  output logic [KW-1:0]     o_motion_y
);

  logic [DW-1:0] r_best;
  logic [KW-1:0] r_mx;
  logic [KW-1:0] r_my;
  logic [DW-1:0] w_slice;
  logic          w_load;

  // Slice mux for the capturing PE.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < BLK; k++) begin
      if (i_cand.k == KW'(k)) w_slice = i_acc[DW*k +: DW];
    end
  end

  // Strict less-than: ties keep the earlier capture.
  assign w_load = i_cap_valid && (i_first || (w_slice < r_best));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best <= '1;
      r_mx   <= '0;
      r_my   <= '0;
    end else if (w_load) begin
      r_best <= w_slice;
      r_mx   <= i_cand.k;
      r_my   <= i_cand.v;
    end
  end

  assign o_best_dist = r_best;
  assign o_motion_x  = r_mx;
  assign o_motion_y  = r_my;

endmodule

// File: rtl/me_control.sv
// Purpose: sequencer for the BLK-PE systolic motion estimator plus best-match reporting.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   start                 : begins a search from IDLE or DONE
//   AddressR              : reference pixel address (row-major)
//   AddressS1 / AddressS2 : search pixel {row, col} for the s1 / s2 buses
//   s1s2mux, newDist      : per-PE bus select and accumulator restart
//   AccIn                 : PE accumulators, PE k on [8k+7:8k]
//   BestDist, motionX, motionY, done : search result
module me_control
  import me_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [RW-1:0]     AddressR,
  output logic [SW-1:0]     AddressS1,
  output logic [SW-1:0]     AddressS2,
  output logic [BLK-1:0]    s1s2mux,
  output logic [BLK-1:0]    newDist,
  input  logic [DW*BLK-1:0] AccIn,
  output logic [DW-1:0]     BestDist,
  output logic [KW-1:0]     motionX,
  output logic [KW-1:0]     motionY,
  output logic              done
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [TW-1:0]    r_t;
  logic             r_first;
  logic             r_done;
  logic             w_run;
  logic             w_enter;
  logic             w_last;
  logic             w_cap;
  logic [KW-1:0]    w_c;
  logic [RW-1:0]    w_u;
  logic [TW-KW-1:0] w_r;
  logic [TW-RW-1:0] w_vblk;
  cand_t            w_cand;

  assign w_run   = (r_state == RUN);
  assign w_enter = start && (r_state != RUN);
  assign w_last  = (r_t == TW'(LAST));
  assign w_c     = r_t[KW-1:0];
  assign w_u     = r_t[RW-1:0];
  assign w_r     = r_t[TW-1:KW];
  assign w_vblk  = r_t[TW-1:RW];

  // PE u finishes a block when t >= BSQ and t mod BSQ == u.
  assign w_cap  = w_run && (w_vblk != '0) && (w_u[RW-1:KW] == '0);
  assign w_cand = '{k: w_c, v: KW'(w_vblk - (TW-RW)'(1))};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; start during RUN is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (start)  w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter, first-capture flag and done flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_t     <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_enter) begin
      r_t     <= '0;
      r_first <= 1'b1;
      r_done  <= 1'b0;
    end else if (w_run) begin
      if (!w_last) r_t <= r_t + TW'(1);
      if (w_cap)   r_first <= 1'b0;
      if (w_last)  r_done <= 1'b1;
    end
  end

  // Address and strobe generation; PE k sees s1 once the column has reached k.
  always_comb begin
    AddressR  = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    s1s2mux   = '0;
    newDist   = '0;
    if (w_run) begin
      AddressR  = w_u;
      AddressS1 = {diag_row(w_r), 1'b0, w_c};
      if (w_r != '0) AddressS2 = {diag_row(w_r - (TW-KW)'(1)), 1'b1, w_c};
      for (int k = 0; k < BLK; k++) s1s2mux[k] = (KW'(k) <= w_c);
      if (w_u[RW-1:KW] == '0) newDist[w_c] = 1'b1;
    end
  end

  me_compare u_compare (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_cap_valid (w_cap),
    .i_first     (r_first),
    .i_cand      (w_cand),
    .i_acc       (AccIn),
    .o_best_dist (BestDist),
    .o_motion_x  (motionX),
    .o_motion_y  (motionY)
  );

  assign done = r_done;

endmodule

// File: tb/tb_me_control.sv
// Directed bench: behavioural 16-PE array with async reference/search memories around me_control.
module tb_me_control;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   AddressR;
  logic [9:0]   AddressS1;
  logic [9:0]   AddressS2;
  logic [15:0]  s1s2mux;
  logic [15:0]  newDist;
  logic [127:0] acc_in;
  logic [7:0]   BestDist;
  logic [3:0]   motionX;
  logic [3:0]   motionY;
  logic         done;

  int checks = 0;
  int errors = 0;
  int edges;

  logic [7:0] ref_mem  [0:255];
  logic [7:0] srch_mem [0:1023];
  logic [7:0] rpr [1:15];
  logic [7:0] acc [0:15];
  logic [7:0] pe_r, pe_s, pe_d;
  int         pe_sum;

  always #5 clock = ~clock;

  me_control dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .AddressR  (AddressR),
    .AddressS1 (AddressS1),
    .AddressS2 (AddressS2),
    .s1s2mux   (s1s2mux),
    .newDist   (newDist),
    .AccIn     (acc_in),
    .BestDist  (BestDist),
    .motionX   (motionX),
    .motionY   (motionY),
    .done      (done)
  );

  // Behavioural PE array: R pipe delays by k, saturating SAD accumulator.
  always @(posedge clock) begin
    for (int k = 1; k < 16; k++) rpr[k] <= (k == 1) ? ref_mem[AddressR] : rpr[k-1];
    for (int k = 0; k < 16; k++) begin
      pe_r   = (k == 0) ? ref_mem[AddressR] : rpr[k];
      pe_s   = s1s2mux[k] ? srch_mem[AddressS1] : srch_mem[AddressS2];
      pe_d   = (pe_r > pe_s) ? pe_r - pe_s : pe_s - pe_r;
      pe_sum = newDist[k] ? int'(pe_d) : int'(acc[k]) + int'(pe_d);
      acc[k] <= (pe_sum > 255) ? 8'hFF : 8'(pe_sum);
    end
  end

  always_comb begin
    acc_in = '0;
    for (int k = 0; k < 16; k++) acc_in[8*k +: 8] = acc[k];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference embedded exactly at (x=5, y=9); f has no other zero-SAD shift.
  task automatic fill_exact();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) srch_mem[r*32+c] = 8'(r*37 + c*11 + r*c*3);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) ref_mem[i*16+j] = 8'((9+i)*37 + (5+j)*11 + (9+i)*(5+j)*3);
  endtask

  // Pattern p(9*row+col-21): exact matches only at (3,2) and (12,1).
  task automatic fill_tie();
    int n;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        n = 9*r + c - 21;
        srch_mem[r*32+c] = 8'(n*n + 3*n + 77);
      end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        n = 9*i + j;
        ref_mem[i*16+j] = 8'(n*n + 3*n + 77);
      end
  endtask

  task automatic fill_sat();
    for (int a = 0; a < 1024; a++) srch_mem[a] = 8'hFF;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'h00;
  endtask

  // Leaves time at start-sampling edge + 1, i.e. t = 0.
  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done, bounded; optional stray start at t=pulse_at.
  task automatic wait_done(input int already, input int pulse_at, output int n);
    n = already;
    while (done !== 1'b1 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
      start = (n == pulse_at);
    end
    start = 1'b0;
  endtask

  initial begin
    // Async reset mid-cycle, no edge needed
    #3 reset_n = 1'b0;
    #1;
    check("rst_idle_best", BestDist, 8'hFF);
    check("rst_idle_mx", motionX, 4'd0);
    check("rst_idle_my", motionY, 4'd0);
    check("rst_idle_done", done, 1'b0);
    check("rst_idle_newdist", newDist, 16'h0000);
    check("rst_idle_addrr", AddressR, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Exact match at (5,9), with strobe spot checks
    fill_exact();
    pulse_start();
    repeat (5) @(posedge clock);
    #1;
    check("t5_addrr", AddressR, 8'd5);
    check("t5_newdist", newDist, 16'h0020);
    check("t5_mux", s1s2mux, 16'h003F);
    check("t5_s1", AddressS1, {5'd0, 5'd5});
    check("t5_s2", AddressS2, 10'd0);
    repeat (15) @(posedge clock);
    #1;
    check("t20_addrr", AddressR, 8'd20);
    check("t20_s1", AddressS1, {5'd1, 5'd4});
    check("t20_s2", AddressS2, {5'd0, 5'd20});
    check("t20_mux", s1s2mux, 16'h001F);
    check("t20_newdist", newDist, 16'h0000);
    wait_done(20, -1, edges);
    check("exact_latency", edges, 4112);
    check("exact_best", BestDist, 8'd0);
    check("exact_mx", motionX, 4'd5);
    check("exact_my", motionY, 4'd9);
    repeat (20) @(posedge clock);
    #1;
    check("hold_done", done, 1'b1);
    check("hold_best", BestDist, 8'd0);
    check("hold_mx", motionX, 4'd5);
    check("hold_my", motionY, 4'd9);
    check("hold_newdist", newDist, 16'h0000);

    // Async reset in DONE
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_done_best", BestDist, 8'hFF);
    check("rst_done_mx", motionX, 4'd0);
    check("rst_done_my", motionY, 4'd0);
    check("rst_done_done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Tie: (12,1) captured at t=524 before (3,2) at t=771
    fill_tie();
    pulse_start();
    wait_done(0, -1, edges);
    check("tie_latency", edges, 4112);
    check("tie_best", BestDist, 8'd0);
    check("tie_mx", motionX, 4'd12);
    check("tie_my", motionY, 4'd1);

    // Saturation, started from DONE: first capture must replace the previous result
    fill_sat();
    pulse_start();
    check("sat_done_clr", done, 1'b0);
    wait_done(0, -1, edges);
    check("sat_latency", edges, 4112);
    check("sat_best", BestDist, 8'hFF);
    check("sat_mx", motionX, 4'd0);
    check("sat_my", motionY, 4'd0);

    // Reset at t=1000, then a full run with a stray start at t=2000
    fill_exact();
    pulse_start();
    repeat (1000) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_run_addrr", AddressR, 8'h00);
    check("rst_run_newdist", newDist, 16'h0000);
    check("rst_run_mux", s1s2mux, 16'h0000);
    check("rst_run_best", BestDist, 8'hFF);
    check("rst_run_mx", motionX, 4'd0);
    check("rst_run_done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    pulse_start();
    check("rerun_t0_addrr", AddressR, 8'd0);
    check("rerun_t0_newdist", newDist, 16'h0001);
    wait_done(0, 2000, edges);
    check("rerun_latency", edges, 4112);
    check("rerun_best", BestDist, 8'd0);
    check("rerun_mx", motionX, 4'd5);
    check("rerun_my", motionY, 4'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
